cr_clic_int_recv: RTL and testbench

CR_CLIC_INT_RECV -- requirements
Module: cr_clic_int_recv

---
 rtl/cr_clic_pkg.sv | 14 +
 rtl/cr_clic_int_cmp.sv | 17 +
 rtl/cr_clic_int_recv.sv | 122 ++++++++++++
 tb/tb_cr_clic_int_recv.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_clic_pkg.sv
// Shared widths and FSM state encoding for the CLIC interrupt receiver.
package cr_clic_pkg;

  localparam int ID_WIDTH = 12;
  localparam int IL_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } clic_state_e;

endpackage

// File: rtl/cr_clic_int_cmp.sv
// Eligibility compare: global enable, non-zero level, above threshold and above in-service level.
module cr_clic_int_cmp #(
  parameter int IL_WIDTH = cr_clic_pkg::IL_WIDTH
) (
  input  logic                mie,
  input  logic [IL_WIDTH-1:0] req_il,
  input  logic [IL_WIDTH-1:0] thresh,
  input  logic [IL_WIDTH-1:0] mil,
  output logic                eligible
);

  assign eligible = mie
                  && (req_il != '0)
                  && (req_il > thresh)
                  && (req_il > mil);

endmodule

// File: rtl/cr_clic_int_recv.sv
// Receives the arbiter's selected interrupt, offers it to the core and runs the
// offer/ack/hold handshake, pulsing an acknowledge back to the interrupt kids.
module cr_clic_int_recv #(
  parameter int ID_WIDTH = cr_clic_pkg::ID_WIDTH,
  parameter int IL_WIDTH = cr_clic_pkg::IL_WIDTH
) (
  input  logic                cpuclk,
  input  logic                cpurst,
  input  logic                arb_ctrl_int_hv,
  input  logic [ID_WIDTH-1:0] arb_ctrl_int_id,
  input  logic [IL_WIDTH-1:0] arb_ctrl_int_il,
  input  logic                arb_ctrl_int_mode,
  input  logic                cp0_clic_mie,
  input  logic [IL_WIDTH-1:0] cp0_clic_mintthresh,
  input  logic [IL_WIDTH-1:0] cp0_clic_mil,
  input  logic                core_clic_int_ack,
  output logic                clic_core_int_vld,
  output logic [ID_WIDTH-1:0] clic_core_int_id,
  output logic [IL_WIDTH-1:0] clic_core_int_il,
  output logic                clic_core_int_hv,
  output logic                clic_core_int_mode,
  output logic                clic_kid_ack_vld,
  output logic [ID_WIDTH-1:0] clic_kid_ack_id
);

  import cr_clic_pkg::*;

  logic eligible;

  cr_clic_int_cmp #(
    .IL_WIDTH (IL_WIDTH)
  ) u_cmp (
    .mie      (cp0_clic_mie),
    .req_il   (arb_ctrl_int_il),
    .thresh   (cp0_clic_mintthresh),
    .mil      (cp0_clic_mil),
    .eligible (eligible)
  );

  clic_state_e         state_q, state_d;
  logic                load;
  logic                hv_q, hv_d;
  logic                mode_q, mode_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [IL_WIDTH-1:0] il_q, il_d;
  logic                vld_q, vld_d;
  logic                ack_vld_q, ack_vld_d;
  logic [ID_WIDTH-1:0] ack_id_q, ack_id_d;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          load    = 1'b1;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        // Ack wins over withdrawal and preemption arriving in the same cycle.
        if (core_clic_int_ack) begin
          state_d = ST_ACK;
        end else if (!eligible) begin
          state_d = ST_IDLE;
        end else if (arb_ctrl_int_il > il_q) begin
          load = 1'b1;
        end
      end
      // HOLD swallows one cycle so the just-acked request, not yet cleared
      // by the kid, is not offered a second time.
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    hv_d      = load ? arb_ctrl_int_hv   : hv_q;
    mode_d    = load ? arb_ctrl_int_mode : mode_q;
    id_d      = load ? arb_ctrl_int_id   : id_q;
    il_d      = load ? arb_ctrl_int_il   : il_q;

    vld_d     = (state_d == ST_PEND);
    ack_vld_d = (state_d == ST_ACK);
    ack_id_d  = (state_d == ST_ACK) ? id_q : '0;
  end

  // NOTE: the offer registers carry a reset because their values are visible
  // on the outputs even while no offer is active; plain data flops elsewhere
  // would not need one.
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q   <= ST_IDLE;
      hv_q      <= 1'b0;
      mode_q    <= 1'b0;
      id_q      <= '0;
      il_q      <= '0;
      vld_q     <= 1'b0;
      ack_vld_q <= 1'b0;
      ack_id_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      hv_q      <= hv_d;
      mode_q    <= mode_d;
      id_q      <= id_d;
      il_q      <= il_d;
      vld_q     <= vld_d;
      ack_vld_q <= ack_vld_d;
      ack_id_q  <= ack_id_d;
    end
  end

  assign clic_core_int_vld  = vld_q;
  assign clic_core_int_id   = id_q;
  assign clic_core_int_il   = il_q;
  assign clic_core_int_hv   = hv_q;
  assign clic_core_int_mode = mode_q;
  assign clic_kid_ack_vld   = ack_vld_q;
  assign clic_kid_ack_id    = ack_id_q;

endmodule

// File: tb/tb_cr_clic_int_recv.sv
// Self-checking bench for cr_clic_int_recv: directed handshake scenarios plus a
// randomized run against a behavioural offer/cooldown model.
module tb_cr_clic_int_recv;

  logic        cpuclk = 1'b0;
  logic        cpurst;
  logic        arb_hv;
  logic [11:0] arb_id;
  logic [7:0]  arb_il;
  logic        arb_mode;
  logic        mie;
  logic [7:0]  thresh;
  logic [7:0]  mil;
  logic        ack;
  logic        vld;
  logic [11:0] off_id;
  logic [7:0]  off_il;
  logic        off_hv;
  logic        off_mode;
  logic        kid_vld;
  logic [11:0] kid_id;

  int total = 0;
  int bad   = 0;

  cr_clic_int_recv dut (
    .cpuclk              (cpuclk),
    .cpurst              (cpurst),
    .arb_ctrl_int_hv     (arb_hv),
    .arb_ctrl_int_id     (arb_id),
    .arb_ctrl_int_il     (arb_il),
    .arb_ctrl_int_mode   (arb_mode),
    .cp0_clic_mie        (mie),
    .cp0_clic_mintthresh (thresh),
    .cp0_clic_mil        (mil),
    .core_clic_int_ack   (ack),
    .clic_core_int_vld   (vld),
    .clic_core_int_id    (off_id),
    .clic_core_int_il    (off_il),
    .clic_core_int_hv    (off_hv),
    .clic_core_int_mode  (off_mode),
    .clic_kid_ack_vld    (kid_vld),
    .clic_kid_ack_id     (kid_id)
  );

  always #5 cpuclk = ~cpuclk;

  // Behavioural model: an offer flag plus a cooldown counter covering the
  // ack-pulse cycle and the following dead cycle.
  logic        m_offering;
  int          m_cool;
  logic        m_hv, m_mode;
  logic [11:0] m_id;
  logic [7:0]  m_il;

  function automatic logic model_eligible();
    return mie && (arb_il != 8'd0) && (arb_il > thresh) && (arb_il > mil);
  endfunction

  task automatic model_clear();
    m_offering = 1'b0;
    m_cool     = 0;
    m_hv       = 1'b0;
    m_mode     = 1'b0;
    m_id       = '0;
    m_il       = '0;
  endtask

  task automatic model_take();
    m_hv   = arb_hv;
    m_mode = arb_mode;
    m_id   = arb_id;
    m_il   = arb_il;
  endtask

  task automatic model_edge();
    logic elig;
    elig = model_eligible();
    if (m_cool > 0) begin
      m_cool = m_cool - 1;
    end else if (m_offering) begin
      if (ack) begin
        m_offering = 1'b0;
        m_cool     = 2;
      end else if (!elig) begin
        m_offering = 1'b0;
      end else if (arb_il > m_il) begin
        model_take();
      end
    end else if (elig) begin
      model_take();
      m_offering = 1'b1;
    end
  endtask

  // One rising edge; outputs are then read 1 time unit later.
  task automatic tick();
    @(posedge cpuclk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    arb_hv   = 1'b0;
    arb_id   = '0;
    arb_il   = '0;
    arb_mode = 1'b0;
    mie      = 1'b1;
    thresh   = '0;
    mil      = '0;
    ack      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge cpuclk);
    cpurst = 1'b1;
    model_clear();
    @(negedge cpuclk);
    @(negedge cpuclk);
    cpurst = 1'b0;
  endtask

  task automatic request(input logic [11:0] id, input logic [7:0] il);
    arb_id   = id;
    arb_il   = il;
    arb_hv   = id[0];
    arb_mode = id[1];
  endtask

  task automatic test_reset();
    cpurst = 1'b1;
    idle_inputs();
    request(12'h5A5, 8'hFF);
    #3;
    model_clear();
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", vld); end
    total++;
    if (off_id !== 12'h0 || off_il !== 8'h0 || off_hv !== 1'b0 || off_mode !== 1'b0) begin
      bad++; $display("FAIL reset_offer got id=%h il=%h hv=%b mode=%b want all 0", off_id, off_il, off_hv, off_mode);
    end
    total++;
    if (kid_vld !== 1'b0 || kid_id !== 12'h0) begin
      bad++; $display("FAIL reset_kid got vld=%b id=%h want 0/0", kid_vld, kid_id);
    end
    repeat (2) @(posedge cpuclk);
    #1;
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL reset_held_vld got=%b want=0", vld); end
    // Eligible request already present at release: first update on the next edge.
    @(negedge cpuclk);
    cpurst = 1'b0;
    tick();
    total++;
    if (vld !== 1'b1 || off_id !== 12'h5A5 || off_il !== 8'hFF) begin
      bad++; $display("FAIL reset_first_edge got vld=%b id=%h il=%h want 1/5a5/ff", vld, off_id, off_il);
    end
    do_reset();
    idle_inputs();
  endtask

  task automatic test_basic_handshake();
    int seen;
    idle_inputs();
    tick();
    request(12'd7, 8'h5F);
    tick();
    total++;
    if (vld !== 1'b1 || off_id !== 12'd7 || off_il !== 8'h5F) begin
      bad++; $display("FAIL basic_offer got vld=%b id=%0d il=%h want 1/7/5f", vld, off_id, off_il);
    end
    tick();
    tick();
    total++;
    if (vld !== 1'b1 || kid_vld !== 1'b0) begin
      bad++; $display("FAIL basic_wait got vld=%b kid=%b want 1/0", vld, kid_vld);
    end
    ack = 1'b1;
    tick();
    total++;
    if (kid_vld !== 1'b1 || kid_id !== 12'd7 || vld !== 1'b0) begin
      bad++; $display("FAIL basic_ack got kid=%b id=%0d vld=%b want 1/7/0", kid_vld, kid_id, vld);
    end
    // Request still asserted during the pulse and the dead cycle, then cleared.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    request(12'd0, 8'h00);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (kid_vld || vld) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL basic_idle got active_cycles=%0d want=0", seen);
    end
  endtask

  task automatic test_hold_no_reoffer();
    idle_inputs();
    request(12'd21, 8'h30);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    total++;
    if (vld !== 1'b0 || kid_vld !== 1'b0) begin
      bad++; $display("FAIL hold_cycle got vld=%b kid=%b want 0/0", vld, kid_vld);
    end
    tick();
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL hold_to_idle got vld=%b want=0", vld); end
    tick();
    total++;
    if (vld !== 1'b1 || off_id !== 12'd21) begin
      bad++; $display("FAIL hold_reoffer got vld=%b id=%0d want 1/21", vld, off_id);
    end
    request(12'd0, 8'h00);
    tick();
  endtask

  task automatic test_threshold();
    int leaks;
    idle_inputs();
    thresh = 8'h40;
    request(12'd11, 8'h40);
    leaks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vld) leaks++;
    end
    total++;
    if (leaks != 0) begin bad++; $display("FAIL thresh_equal got vld_cycles=%0d want=0", leaks); end
    mil = 8'h40;
    thresh = 8'h3F;
    tick();
    total++;
    if (vld !== 1'b0) begin bad++; $display("FAIL mil_equal got vld=%b want=0", vld); end
    mil = 8'h00;
    tick();
    total++;
    if (vld !== 1'b1 || off_il !== 8'h40) begin
      bad++; $display("FAIL thresh_pass got vld=%b il=%h want 1/40", vld, off_il);
    end
    request(12'd0, 8'h00);
    tick();
  endtask

  task automatic test_preemption();
    idle_inputs();
    request(12'd3, 8'h20);
    tick();
    request(12'd9, 8'h80);
    tick();
    total++;
    if (vld !== 1'b1 || off_id !== 12'd9 || off_il !== 8'h80 || off_hv !== 1'b1) begin
      bad++; $display("FAIL preempt_reload got vld=%b id=%0d il=%h hv=%b want 1/9/80/1", vld, off_id, off_il, off_hv);
    end
    request(12'd5, 8'h80);
    tick();
    total++;
    if (off_id !== 12'd9) begin bad++; $display("FAIL preempt_equal got id=%0d want=9", off_id); end
    request(12'd0, 8'h00);
    tick();
    request(12'd3, 8'h20);
    tick();
    request(12'd9, 8'h80);
    ack = 1'b1;
    tick();
    total++;
    if (kid_vld !== 1'b1 || kid_id !== 12'd3 || off_id !== 12'd3) begin
      bad++; $display("FAIL preempt_ack_prio got kid=%b kid_id=%0d off_id=%0d want 1/3/3", kid_vld, kid_id, off_id);
    end
    ack = 1'b0;
    request(12'd0, 8'h00);
    tick();
    tick();
  endtask

  task automatic test_withdraw();
    int pulses;
    idle_inputs();
    request(12'd44, 8'h10);
    tick();
    request(12'd44, 8'h00);
    tick();
    total++;
    if (vld !== 1'b0 || kid_vld !== 1'b0 || off_id !== 12'd44) begin
      bad++; $display("FAIL withdraw got vld=%b kid=%b id=%0d want 0/0/44", vld, kid_vld, off_id);
    end
    ack = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (kid_vld || vld) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL withdraw_late_ack got active_cycles=%0d want=0", pulses); end
    ack = 1'b0;
  endtask

  task automatic test_reset_in_ack();
    idle_inputs();
    request(12'd77, 8'h33);
    tick();
    ack = 1'b1;
    tick();
    total++;
    if (kid_vld !== 1'b1) begin bad++; $display("FAIL rst_ack_setup got kid=%b want=1", kid_vld); end
    ack = 1'b0;
    request(12'd0, 8'h00);
    cpurst = 1'b1;
    model_clear();
    #1;
    total++;
    if (kid_vld !== 1'b0 || kid_id !== 12'd0 || vld !== 1'b0 || off_id !== 12'd0 || off_il !== 8'd0) begin
      bad++; $display("FAIL rst_ack_async got kid=%b kid_id=%0d vld=%b id=%0d il=%h want all 0", kid_vld, kid_id, vld, off_id, off_il);
    end
    @(negedge cpuclk);
    cpurst = 1'b0;
    tick();
    total++;
    if (kid_vld !== 1'b0 || vld !== 1'b0) begin
      bad++; $display("FAIL rst_ack_after got kid=%b vld=%b want 0/0", kid_vld, vld);
    end
  endtask

  task automatic test_random();
    int errs;
    logic [11:0] exp_kid_id;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      arb_hv   = 1'($urandom);
      arb_mode = 1'($urandom);
      if ($urandom_range(0, 3) == 0) arb_id = arb_id;
      else arb_id = 12'($urandom);
      if ($urandom_range(0, 4) == 0) arb_il = 8'h00;
      else if ($urandom_range(0, 2) == 0) arb_il = arb_il;
      else arb_il = 8'($urandom_range(0, 255));
      mie    = ($urandom_range(0, 9) != 0);
      thresh = 8'($urandom_range(0, 96));
      mil    = 8'($urandom_range(0, 96));
      ack    = ($urandom_range(0, 3) == 0);
      tick();
      exp_kid_id = (m_cool == 2) ? m_id : 12'd0;
      total++;
      if (vld !== m_offering || kid_vld !== (m_cool == 2) || kid_id !== exp_kid_id ||
          off_id !== m_id || off_il !== m_il || off_hv !== m_hv || off_mode !== m_mode) begin
        bad++;
        errs++;
        if (errs <= 5)
          $display("FAIL random[%0d] got vld=%b kid=%b/%h off=%h/%h/%b/%b want vld=%b kid=%b/%h off=%h/%h/%b/%b",
                   i, vld, kid_vld, kid_id, off_id, off_il, off_hv, off_mode,
                   m_offering, (m_cool == 2), exp_kid_id, m_id, m_il, m_hv, m_mode);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_handshake();
    test_hold_no_reoffer();
    test_threshold();
    test_preemption();
    test_withdraw();
    test_reset_in_ack();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
